// File: rtl/pacman_dir_buffer_if.sv
// rtl/pacman_dir_buffer_if.sv - joystick/maze/heading signal bundle for the Pac-Man direction buffer
interface pacman_dir_buffer_if;
    logic [3:0] btn_raw;
    logic [3:0] legal_moves;
    logic       move_tick;
    logic [3:0] curr_direction;
    logic [3:0] pending_dir;
    logic       pending_valid;
    logic       dir_changed;
    logic       stalled;

    modport master (
        output btn_raw, legal_moves, move_tick,
        input  curr_direction, pending_dir, pending_valid, dir_changed, stalled
    );

    modport slave (
        input  btn_raw, legal_moves, move_tick,
        output curr_direction, pending_dir, pending_valid, dir_changed, stalled
    );
endinterface

// File: rtl/pacman_dir_buffer.sv
// rtl/pacman_dir_buffer.sv - button sync/debounce/press detect with buffered, timed-out turn requests
module pacman_dir_buffer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_TICKS      = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    pacman_dir_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    HOLD_INIT = 8'(HOLD_TICKS);

    logic [3:0]    sync1, sync2, deb, deb_prev;
    logic [CW-1:0] cnt [4];

    logic [3:0] curr, curr_nx;
    logic [3:0] pend, pend_nx;
    logic       pend_v, pend_v_nx;
    logic [7:0] hold, hold_nx;
    logic       stall, stall_nx;
    logic       chg;

    logic [3:0] press, winner, opposite;
    logic       reversal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= bus.btn_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Only rising debounced levels count; releases and held buttons produce nothing.
    assign press    = deb & ~deb_prev;
    assign opposite = {curr[2], curr[3], curr[0], curr[1]};

    always_comb begin
        winner = 4'b0000;
        if (press[0])      winner = 4'b0001;
        else if (press[1]) winner = 4'b0010;
        else if (press[2]) winner = 4'b0100;
        else if (press[3]) winner = 4'b1000;
    end

    assign reversal = (winner != 4'b0000) && (winner == opposite);

    // Tick resolves the old request first; a same-cycle press then overrides its result.
    always_comb begin
        curr_nx   = curr;
        pend_nx   = pend;
        pend_v_nx = pend_v;
        hold_nx   = hold;
        stall_nx  = stall;
        if (bus.move_tick) begin
            if (pend_v && ((pend & bus.legal_moves) != 4'b0000)) begin
                curr_nx   = pend;
                pend_nx   = 4'b0000;
                pend_v_nx = 1'b0;
                hold_nx   = 8'd0;
            end else if (pend_v) begin
                hold_nx = hold - 8'd1;
                if (hold == 8'd1) begin
                    pend_nx   = 4'b0000;
                    pend_v_nx = 1'b0;
                end
            end
            stall_nx = ((curr_nx & bus.legal_moves) == 4'b0000);
        end
        if (reversal) begin
            curr_nx   = winner;
            pend_nx   = 4'b0000;
            pend_v_nx = 1'b0;
            hold_nx   = 8'd0;
            stall_nx  = 1'b0;
        end else if (winner != 4'b0000) begin
            pend_nx   = winner;
            pend_v_nx = 1'b1;
            hold_nx   = HOLD_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            curr   <= 4'b0001;
            pend   <= 4'b0000;
            pend_v <= 1'b0;
            hold   <= 8'd0;
            stall  <= 1'b0;
            chg    <= 1'b0;
        end else begin
            curr   <= curr_nx;
            pend   <= pend_nx;
            pend_v <= pend_v_nx;
            hold   <= hold_nx;
            stall  <= stall_nx;
            chg    <= (curr_nx != curr);
        end
    end

    assign bus.curr_direction = curr;
    assign bus.pending_dir    = pend;
    assign bus.pending_valid  = pend_v;
    assign bus.dir_changed    = chg;
    assign bus.stalled        = stall;
endmodule

// File: tb/tb_pacman_dir_buffer.sv
// tb/tb_pacman_dir_buffer.sv - directed and randomized checks of pacman_dir_buffer against a turn-rule model
module tb_pacman_dir_buffer;
    localparam int DEB  = 4;
    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    pacman_dir_buffer_if bus();

    pacman_dir_buffer #(.DEBOUNCE_CYCLES(DEB), .HOLD_TICKS(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Directions are indices 0..3 (left,right,up,down); -1 means no request.
    logic [3:0] m_hist[$];
    logic [3:0] m_db, m_dbq;
    int         m_run[4];
    int         m_cur, m_pend, m_hold;
    logic       m_chg, m_stall;

    function automatic logic [3:0] onehot(input int d);
        logic [3:0] v;
        v = 4'b0000;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_hist = {4'h0, 4'h0};
        m_db = 4'h0;
        m_dbq = 4'h0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_cur = 0;
        m_pend = -1;
        m_hold = 0;
        m_chg = 1'b0;
        m_stall = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] btn, input logic [3:0] legal, input logic tick);
        int win, prev;
        logic [3:0] s;
        win = -1;
        for (int i = 0; i < 4; i++)
            if (m_db[i] && !m_dbq[i] && win < 0) win = i;
        m_dbq = m_db;
        s = m_hist.pop_front();
        m_hist.push_back(btn);
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i] = s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        prev = m_cur;
        if (tick) begin
            if (m_pend >= 0 && legal[m_pend]) begin
                m_cur = m_pend;
                m_pend = -1;
            end else if (m_pend >= 0) begin
                m_hold--;
                if (m_hold == 0) m_pend = -1;
            end
            m_stall = !legal[m_cur];
        end
        if (win >= 0) begin
            if (win == (prev ^ 1)) begin
                m_cur = win;
                m_pend = -1;
                m_stall = 1'b0;
            end else begin
                m_pend = win;
                m_hold = HOLD;
            end
        end
        m_chg = (m_cur != prev);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] b, input logic [3:0] l, input logic t);
        bus.btn_raw = b;
        bus.legal_moves = l;
        bus.move_tick = t;
        @(posedge clk);
        model_step(b, l, t);
        #1;
        chk("curr_direction", bus.curr_direction, onehot(m_cur));
        chk("pending_dir", bus.pending_dir, onehot(m_pend));
        chk("pending_valid", {3'b0, bus.pending_valid}, {3'b0, (m_pend >= 0)});
        chk("dir_changed", {3'b0, bus.dir_changed}, {3'b0, m_chg});
        chk("stalled", {3'b0, bus.stalled}, {3'b0, m_stall});
    endtask

    task automatic do_reset(input logic [3:0] b);
        rst_n = 1'b0;
        bus.btn_raw = b;
        bus.legal_moves = 4'h0;
        bus.move_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_curr", bus.curr_direction, 4'b0001);
        chk("rst_pending_valid", {3'b0, bus.pending_valid}, 4'h0);
        chk("rst_pending_dir", bus.pending_dir, 4'h0);
        chk("rst_dir_changed", {3'b0, bus.dir_changed}, 4'h0);
        chk("rst_stalled", {3'b0, bus.stalled}, 4'h0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rb, rl;
        logic       rt;

        // Reset with all buttons held; the held press surfaces DEB+3 cycles after release.
        do_reset(4'hF);
        for (int n = 1; n <= 7; n++) begin
            cyc(4'hF, 4'h0, 1'b0);
            chk("rst_press_timing", {3'b0, bus.pending_valid}, {3'b0, (n == 7)});
        end
        chk("rst_press_left_wins", bus.pending_dir, 4'b0001);
        repeat (10) cyc(4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'b0001, 1'b1);
        chk("same_dir_taken", {3'b0, bus.pending_valid}, 4'h0);

        // Debounce: short pulse ignored, held press appears once at cycle DEB+3.
        repeat (3) cyc(4'b0100, 4'h0, 1'b0);
        repeat (10) cyc(4'h0, 4'h0, 1'b0);
        chk("short_pulse", {3'b0, bus.pending_valid}, 4'h0);
        for (int n = 1; n <= 10; n++) begin
            cyc(4'b0100, 4'h0, 1'b0);
            chk("deb_timing", {3'b0, bus.pending_valid}, {3'b0, (n >= 7)});
        end
        chk("deb_dir", bus.pending_dir, 4'b0100);
        repeat (10) cyc(4'h0, 4'h0, 1'b0);

        // Buffered turn: survives illegal ticks, taken on the legal one.
        cyc(4'h0, 4'b0001, 1'b1);
        chk("buf_tick1", {3'b0, bus.pending_valid}, 4'h1);
        cyc(4'h0, 4'b0001, 1'b1);
        chk("buf_tick2", {3'b0, bus.pending_valid}, 4'h1);
        cyc(4'h0, 4'b0101, 1'b1);
        chk("buf_turn_dir", bus.curr_direction, 4'b0100);
        chk("buf_turn_pulse", {3'b0, bus.dir_changed}, 4'h1);
        chk("buf_turn_clear", {3'b0, bus.pending_valid}, 4'h0);
        cyc(4'h0, 4'h0, 1'b0);
        chk("buf_pulse_end", {3'b0, bus.dir_changed}, 4'h0);

        // Timeout: request expires on the HOLD-th illegal tick.
        repeat (8) cyc(4'b0001, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'b0010, 1'b1);
        chk("to_tick1", {3'b0, bus.pending_valid}, 4'h1);
        chk("to_stalled", {3'b0, bus.stalled}, 4'h1);
        cyc(4'h0, 4'b0010, 1'b1);
        chk("to_tick2", {3'b0, bus.pending_valid}, 4'h1);
        cyc(4'h0, 4'b0010, 1'b1);
        chk("to_tick3", {3'b0, bus.pending_valid}, 4'h0);
        chk("to_heading", bus.curr_direction, 4'b0100);

        // Reversal applied one cycle after the press pulse, no tick needed.
        for (int n = 1; n <= 7; n++) begin
            cyc(4'b1000, 4'h0, 1'b0);
            chk("rev_timing", bus.curr_direction, (n == 7) ? 4'b1000 : 4'b0100);
        end
        chk("rev_pulse", {3'b0, bus.dir_changed}, 4'h1);
        chk("rev_no_pending", {3'b0, bus.pending_valid}, 4'h0);
        chk("rev_unstall", {3'b0, bus.stalled}, 4'h0);
        repeat (3) cyc(4'b1000, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'h0, 1'b0);

        // Left and up in the same cycle: left wins.
        repeat (7) cyc(4'b0101, 4'h0, 1'b0);
        chk("prio_left", bus.pending_dir, 4'b0001);
        repeat (3) cyc(4'b0101, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'h0, 1'b0);

        // Stall and press/tick overlap.
        cyc(4'h0, 4'b0001, 1'b1);
        repeat (10) cyc(4'b0010, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'h0, 1'b0);
        chk("heading_right", bus.curr_direction, 4'b0010);
        cyc(4'h0, 4'b0001, 1'b1);
        chk("stall_set", {3'b0, bus.stalled}, 4'h1);
        repeat (10) cyc(4'b1000, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'h0, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            cyc(4'b0100, (n == 7) ? 4'b1000 : 4'h0, (n == 7));
            if (n == 7) begin
                chk("ovl_old_taken", bus.curr_direction, 4'b1000);
                chk("ovl_new_pending", bus.pending_dir, 4'b0100);
                chk("ovl_valid", {3'b0, bus.pending_valid}, 4'h1);
            end
        end
        repeat (8) cyc(4'h0, 4'h0, 1'b0);

        // Randomized phase with a reset in the middle of activity.
        rb = 4'h0;
        for (int i = 0; i < 1600; i++) begin
            if (i == 800) do_reset(rb);
            if ($urandom_range(0, 9) == 0) rb = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            rt = ($urandom_range(0, 3) == 0);
            cyc(rb, rl, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
